// File: rtl/usrt_pkg.sv
// Shared APB-master state encoding and USRT register map for the bus master and its sequencers.
// Pure declarations: no logic, no latency, no flow control.
package usrt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   localparam logic [31:0] USRT_TX_ADDR      = 32'h0000_0000;
   localparam logic [31:0] USRT_RX_ADDR      = 32'h0000_0004;
   localparam logic [31:0] USRT_STAT_WR_ADDR = 32'h0000_0008;
   localparam logic [31:0] USRT_STAT_RD_ADDR = 32'h0000_000C;

endpackage

// File: rtl/apb_wdog.sv
// Wait-state watchdog: clear wins over increment; expired_o is combinational off the count.
// Flags expiry when TIMEOUT-1 wait cycles have been counted; no flow control.
module apb_wdog #(
   parameter int TIMEOUT = 16,
   localparam int W = $clog2(TIMEOUT) + 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Command-driven APB master: one transfer in flight, response 3 cycles after the command cycle (+1 per wait).
// Command stalls (Cmd_Ready=0) outside IDLE; response holds until Rsp_Ready; watchdog aborts hung slaves.
module apb_master
   import usrt_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              i_Pclk,
   input  logic              i_Preset,
   input  logic              i_Cmd_Valid,
   output logic              o_Cmd_Ready,
   input  logic              i_Cmd_Write,
   input  logic [ADDR_W-1:0] i_Cmd_Addr,
   input  logic [DATA_W-1:0] i_Cmd_Wdata,
   output logic              o_Rsp_Valid,
   input  logic              i_Rsp_Ready,
   output logic [DATA_W-1:0] o_Rsp_Rdata,
   output logic              o_Rsp_Err,
   output logic              o_Psel,
   output logic              o_Penable,
   output logic              o_Pwrite,
   output logic [ADDR_W-1:0] o_Paddr,
   output logic [DATA_W-1:0] o_Pwdata,
   input  logic [DATA_W-1:0] i_Prdata,
   input  logic              i_Pready
);

   apb_state_t        state_q;
   logic              cmd_rdy_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_vld_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   logic cmd_fire;
   logic wdog_inc;
   logic wdog_exp;

   assign cmd_fire = (state_q == IDLE) && i_Cmd_Valid && cmd_rdy_q;
   assign wdog_inc = (state_q == ACCESS) && !i_Pready && !wdog_exp;

   apb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i     (i_Pclk),
      .rst_ni    (i_Preset),
      .clr_i     (cmd_fire),
      .inc_i     (wdog_inc),
      .expired_o (wdog_exp)
   );

   always_ff @(posedge i_Pclk) begin
      if (!i_Preset) begin
         state_q     <= IDLE;
         cmd_rdy_q   <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  cmd_rdy_q <= 1'b0;
                  psel_q    <= 1'b1;
                  pwrite_q  <= i_Cmd_Write;
                  paddr_q   <= i_Cmd_Addr;
                  // Reads leave the last write data on the bus rather than toggling it.
                  if (i_Cmd_Write) begin
                     pwdata_q <= i_Cmd_Wdata;
                  end
                  state_q   <= SETUP;
               end else begin
                  cmd_rdy_q <= 1'b1;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // Pready on the expiry cycle still completes the transfer normally.
               if (i_Pready) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_vld_q   <= 1'b1;
                  rsp_rdata_q <= pwrite_q ? '0 : i_Prdata;
                  rsp_err_q   <= 1'b0;
                  state_q     <= RESP;
               end else if (wdog_exp) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_vld_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (i_Rsp_Ready) begin
                  rsp_vld_q <= 1'b0;
                  cmd_rdy_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_Cmd_Ready = cmd_rdy_q;
   assign o_Psel      = psel_q;
   assign o_Penable   = penable_q;
   assign o_Pwrite    = pwrite_q;
   assign o_Paddr     = paddr_q;
   assign o_Pwdata    = pwdata_q;
   assign o_Rsp_Valid = rsp_vld_q;
   assign o_Rsp_Rdata = rsp_rdata_q;
   assign o_Rsp_Err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus stall and mid-transfer reset sequences.
module tb_apb_master;
   import usrt_pkg::*;

   logic        clk = 1'b0;
   logic        i_Preset;
   logic        i_Cmd_Valid;
   logic        o_Cmd_Ready;
   logic        i_Cmd_Write;
   logic [31:0] i_Cmd_Addr;
   logic [7:0]  i_Cmd_Wdata;
   logic        o_Rsp_Valid;
   logic        i_Rsp_Ready;
   logic [7:0]  o_Rsp_Rdata;
   logic        o_Rsp_Err;
   logic        o_Psel;
   logic        o_Penable;
   logic        o_Pwrite;
   logic [31:0] o_Paddr;
   logic [7:0]  o_Pwdata;
   logic [7:0]  i_Prdata;
   logic        i_Pready;

   int n_chk  = 0;
   int n_pass = 0;

   apb_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(16)) dut (
      .i_Pclk      (clk),
      .i_Preset    (i_Preset),
      .i_Cmd_Valid (i_Cmd_Valid),
      .o_Cmd_Ready (o_Cmd_Ready),
      .i_Cmd_Write (i_Cmd_Write),
      .i_Cmd_Addr  (i_Cmd_Addr),
      .i_Cmd_Wdata (i_Cmd_Wdata),
      .o_Rsp_Valid (o_Rsp_Valid),
      .i_Rsp_Ready (i_Rsp_Ready),
      .o_Rsp_Rdata (o_Rsp_Rdata),
      .o_Rsp_Err   (o_Rsp_Err),
      .o_Psel      (o_Psel),
      .o_Penable   (o_Penable),
      .o_Pwrite    (o_Pwrite),
      .o_Paddr     (o_Paddr),
      .o_Pwdata    (o_Pwdata),
      .i_Prdata    (i_Prdata),
      .i_Pready    (i_Pready)
   );

   always #5 clk = ~clk;

   // waits = ACCESS cycles with Pready low before the slave answers (large = never answers)
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  prdata;
      int          waits;
      int          exp_pen;
      logic [7:0]  exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc, psel_n, pen_n, rsp_cyc, bus_bad, rdy_bad;
      logic [7:0] rdata;
      logic err;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_rdy", idx), o_Cmd_Ready, 1);
      chk($sformatf("v%0d_rsp_idle", idx), o_Rsp_Valid, 0);
      i_Cmd_Valid = 1'b1;
      i_Cmd_Write = v.wr;
      i_Cmd_Addr  = v.addr;
      i_Cmd_Wdata = v.wdata;
      i_Prdata    = v.prdata;
      i_Rsp_Ready = 1'b1;
      i_Pready    = 1'b0;
      cyc = 0; psel_n = 0; pen_n = 0; rsp_cyc = -1; bus_bad = 0; rdy_bad = 0;
      rdata = '0; err = 1'b0;
      while (rsp_cyc < 0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         i_Cmd_Valid = 1'b0;
         if (o_Cmd_Ready) rdy_bad++;
         if (o_Psel) begin
            psel_n++;
            if (o_Paddr !== v.addr || o_Pwrite !== v.wr || (v.wr && o_Pwdata !== v.wdata))
               bus_bad++;
         end
         if (o_Penable) begin
            pen_n++;
            i_Pready = (pen_n > v.waits);
         end else begin
            i_Pready = 1'b0;
         end
         if (o_Rsp_Valid) begin
            rsp_cyc = cyc;
            rdata   = o_Rsp_Rdata;
            err     = o_Rsp_Err;
         end
      end
      chk($sformatf("v%0d_rsp_cyc", idx), rsp_cyc, v.exp_pen + 2);
      chk($sformatf("v%0d_psel_cycles", idx), psel_n, v.exp_pen + 1);
      chk($sformatf("v%0d_penable_cycles", idx), pen_n, v.exp_pen);
      chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", idx), err, v.exp_err);
      chk($sformatf("v%0d_bus_stable", idx), bus_bad, 0);
      chk($sformatf("v%0d_cmd_rdy_low", idx), rdy_bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      vecs[0] = '{1'b1, USRT_TX_ADDR,      8'hA5, 8'hC3, 0,   1,  8'h00, 1'b0};
      vecs[1] = '{1'b0, USRT_RX_ADDR,      8'h00, 8'h3C, 3,   4,  8'h3C, 1'b0};
      vecs[2] = '{1'b0, USRT_STAT_RD_ADDR, 8'h00, 8'h77, 999, 16, 8'h00, 1'b1};
      vecs[3] = '{1'b0, USRT_RX_ADDR,      8'h00, 8'h5A, 15,  16, 8'h5A, 1'b0};
      vecs[4] = '{1'b1, USRT_STAT_WR_ADDR, 8'h0F, 8'hFF, 2,   3,  8'h00, 1'b0};
      vecs[5] = '{1'b1, USRT_TX_ADDR,      8'h81, 8'h42, 999, 16, 8'h00, 1'b1};
      vecs[6] = '{1'b0, 32'hDEAD_BEEC,     8'h00, 8'h81, 0,   1,  8'h81, 1'b0};

      i_Preset    = 1'b0;
      i_Cmd_Valid = 1'b0;
      i_Cmd_Write = 1'b0;
      i_Cmd_Addr  = '0;
      i_Cmd_Wdata = '0;
      i_Rsp_Ready = 1'b0;
      i_Prdata    = '0;
      i_Pready    = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cmd_rdy", o_Cmd_Ready, 0);
      chk("rst_psel",    o_Psel, 0);
      chk("rst_penable", o_Penable, 0);
      chk("rst_rsp_vld", o_Rsp_Valid, 0);
      chk("rst_paddr",   o_Paddr, 0);
      chk("rst_pwrite",  o_Pwrite, 0);
      chk("rst_pwdata",  o_Pwdata, 0);
      chk("rst_rdata",   o_Rsp_Rdata, 0);
      chk("rst_err",     o_Rsp_Err, 0);
      i_Preset = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Response stall: a second command waits while the first response is held.
      @(negedge clk);
      i_Cmd_Valid = 1'b1;
      i_Cmd_Write = 1'b0;
      i_Cmd_Addr  = USRT_RX_ADDR;
      i_Prdata    = 8'h99;
      i_Rsp_Ready = 1'b0;
      i_Pready    = 1'b1;
      repeat (3) @(negedge clk);
      chk("stall_rsp_vld_first", o_Rsp_Valid, 1);
      i_Prdata = 8'h00;
      i_Cmd_Addr = USRT_TX_ADDR;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_rsp_vld", k), o_Rsp_Valid, 1);
         chk($sformatf("stall%0d_rdata", k),   o_Rsp_Rdata, 8'h99);
         chk($sformatf("stall%0d_cmd_rdy", k), o_Cmd_Ready, 0);
         chk($sformatf("stall%0d_psel", k),    o_Psel, 0);
      end
      i_Rsp_Ready = 1'b1;
      i_Cmd_Valid = 1'b0;
      i_Pready    = 1'b0;
      @(negedge clk);
      chk("stall_rsp_drop", o_Rsp_Valid, 0);
      chk("stall_cmd_rdy",  o_Cmd_Ready, 1);

      // Reset in the middle of a hung ACCESS phase.
      @(negedge clk);
      i_Cmd_Valid = 1'b1;
      i_Cmd_Write = 1'b0;
      i_Cmd_Addr  = USRT_STAT_RD_ADDR;
      @(negedge clk);
      i_Cmd_Valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_penable", o_Penable, 1);
      i_Preset = 1'b0;
      @(negedge clk);
      chk("mid_rst_psel",    o_Psel, 0);
      chk("mid_rst_penable", o_Penable, 0);
      chk("mid_rst_rsp_vld", o_Rsp_Valid, 0);
      chk("mid_rst_cmd_rdy", o_Cmd_Ready, 0);
      i_Preset = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_rdy", o_Cmd_Ready, 1);
      chk("post_rst_psel",    o_Psel, 0);
      run_vec(vecs[1], 7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
